// File: rtl/opendap_swd_link_ctrl.sv
// opendap_swd_link_ctrl: SWD link state tracking and request header decode.
// Hands each good header to the data-phase engine, then ignores the line until phase_done.
module opendap_swd_link_ctrl #(
    parameter bit FIRST_DPIDR = 1'b1,
    parameter bit PARK_CHECK  = 1'b1
) (
    input  logic       swclk,
    input  logic       rst_n,
    input  logic       i_swdi_reg,
    input  logic       i_enter_dormant,
    input  logic       i_exit_dormant,
    input  logic       i_line_reset,
    input  logic       i_phase_done,
    output logic       o_link_dormant,
    output logic       o_link_lockout,
    output logic       o_req_valid,
    output logic       o_req_apndp,
    output logic       o_req_rnw,
    output logic [1:0] o_req_addr,
    output logic       o_req_err
);
    typedef enum logic [2:0] {
        S_DORMANT, S_RESET, S_IDLE, S_HEADER, S_BUSY, S_LOCKOUT
    } state_t;

    state_t      r_state, w_state;
    logic        r_seen_lr, w_seen_lr;
    logic        r_first, w_first;
    logic [2:0]  r_cnt, w_cnt;
    logic [5:0]  r_sh;
    logic        r_req_valid, w_req_valid;
    logic        r_req_err, w_req_err;
    logic        r_apndp, r_rnw;
    logic [1:0]  r_addr;
    logic [6:0]  w_hdr;
    logic        w_frame_ok, w_first_ok;

    // {park, stop, parity, A3, A2, RnW, APnDP}; the park bit is the live input on the last sample
    assign w_hdr      = {i_swdi_reg, r_sh};
    assign w_frame_ok = (w_hdr[4] == ^w_hdr[3:0]) && !w_hdr[5] && (w_hdr[6] || !PARK_CHECK);
    assign w_first_ok = !FIRST_DPIDR || !r_first || (w_hdr[3:0] == 4'b0010);

    always_comb begin
        w_state     = r_state;
        w_seen_lr   = r_seen_lr;
        w_first     = r_first;
        w_cnt       = r_cnt;
        w_req_valid = 1'b0;
        w_req_err   = 1'b0;
        if (i_enter_dormant) begin
            w_state = S_DORMANT;
        end else if (i_line_reset && r_state != S_DORMANT) begin
            w_state   = S_RESET;
            w_seen_lr = 1'b1;
            w_first   = 1'b1;
        end else begin
            case (r_state)
                S_DORMANT: if (i_exit_dormant) begin
                    w_state   = S_RESET;
                    w_seen_lr = 1'b0;
                end
                S_RESET: if (r_seen_lr && !i_swdi_reg) begin
                    w_state   = S_IDLE;
                    w_seen_lr = 1'b0;
                end
                S_IDLE: if (i_swdi_reg) begin
                    w_state = S_HEADER;
                    w_cnt   = 3'd0;
                end
                S_HEADER: begin
                    w_cnt = r_cnt + 3'd1;
                    if (r_cnt == 3'd6) begin
                        w_req_valid = w_frame_ok && w_first_ok;
                        w_req_err   = !w_req_valid;
                        w_state     = w_req_valid ? S_BUSY : S_LOCKOUT;
                        w_first     = w_req_valid ? 1'b0 : r_first;
                    end
                end
                S_BUSY:    if (i_phase_done) w_state = S_IDLE;
                S_LOCKOUT: w_state = S_LOCKOUT;
                default:   w_state = S_DORMANT;
            endcase
        end
    end

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_DORMANT;
            r_seen_lr   <= 1'b0;
            r_first     <= 1'b1;
            r_cnt       <= 3'd0;
            r_sh        <= 6'd0;
            r_req_valid <= 1'b0;
            r_req_err   <= 1'b0;
            r_apndp     <= 1'b0;
            r_rnw       <= 1'b0;
            r_addr      <= 2'd0;
        end else begin
            r_state     <= w_state;
            r_seen_lr   <= w_seen_lr;
            r_first     <= w_first;
            r_cnt       <= w_cnt;
            r_sh        <= {i_swdi_reg, r_sh[5:1]};
            r_req_valid <= w_req_valid;
            r_req_err   <= w_req_err;
            if (w_req_valid) begin
                r_apndp <= w_hdr[0];
                r_rnw   <= w_hdr[1];
                r_addr  <= w_hdr[3:2];
            end
        end
    end

    assign o_link_dormant = (r_state == S_DORMANT);
    assign o_link_lockout = (r_state == S_LOCKOUT);
    assign o_req_valid    = r_req_valid;
    assign o_req_err      = r_req_err;
    assign o_req_apndp    = r_apndp;
    assign o_req_rnw      = r_rnw;
    assign o_req_addr     = r_addr;
endmodule
